// File: rtl/divisor_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ITERA  = 2'd1,
    AJUSTE = 2'd2
  } estado_t;

  localparam int   N_DEF        = 3;
  // Replicated to N bits for the divide-by-zero quotient (all ones).
  localparam logic COC_DIV0_BIT = 1'b1;

endpackage

// File: rtl/caminodatos_div.sv
// A/Q/M register datapath of the restoring divider: load, shift-left-and-subtract,
// and restore selection driven by strobes from the controlling FSM.
module caminodatos_div
  import divisor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic         desplaza,
  input  logic         restaura,
  input  logic [N-1:0] dvd_mag,
  input  logic [N-1:0] dvs_mag,
  output logic [N:0]   a,
  output logic [N-1:0] q,
  output logic         t_neg
);

  logic [N-1:0] m;
  logic [N:0]   a_sh;
  logic [N:0]   t;
  logic [N-1:0] q_sh;

  // Trial subtraction on the shifted partial remainder; sign bit picks restore.
  always_comb begin
    a_sh = {a[N-1:0], q[N-1]};
    q_sh = {q[N-2:0], 1'b0};
    t    = a_sh - {1'b0, m};
  end

  assign t_neg = t[N];

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      q <= '0;
      m <= '0;
    end else if (carga) begin
      a <= '0;
      q <= dvd_mag;
      m <= dvs_mag;
    end else if (desplaza) begin
      if (restaura) begin
        a <= a_sh;
        q <= q_sh;
      end else begin
        a <= t;
        q <= {q[N-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential N-bit restoring divider with start/listo handshake.
// Macro DIVISOR_CON_SIGNO_EN selects two's-complement signed operation; unsigned otherwise.
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto,
  output logic         listo,
  output logic         ocupado,
  output logic         div_cero
);

  localparam int CW = $clog2(N + 1);

  estado_t       estado, estado_sig;
  logic [CW-1:0] cnt;
  logic          sgn_dvd, sgn_dvs, es_cero;
  logic          sgn_dvd_in, sgn_dvs_in;
  logic          acepta, carga, desplaza, restaura, t_neg;
  logic [N-1:0]  dvd_mag, dvs_mag, q;
  logic [N:0]    a;

  function automatic logic [N-1:0] negar(input logic [N-1:0] v);
    return (~v) + N'(1);
  endfunction

`ifdef DIVISOR_CON_SIGNO_EN
  // Magnitudes are N-bit unsigned, so |-2^(N-1)| still fits.
  assign sgn_dvd_in = dividendo[N-1];
  assign sgn_dvs_in = divisor[N-1];
  assign dvd_mag    = sgn_dvd_in ? negar(dividendo) : dividendo;
  assign dvs_mag    = sgn_dvs_in ? negar(divisor) : divisor;
`else
  assign sgn_dvd_in = 1'b0;
  assign sgn_dvs_in = 1'b0;
  assign dvd_mag    = dividendo;
  assign dvs_mag    = divisor;
`endif

  assign acepta = (estado == REPOSO) && start;

  always_ff @(posedge clk) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: if (start) estado_sig = (divisor == '0) ? AJUSTE : ITERA;
      ITERA:  if (cnt == CW'(1)) estado_sig = AJUSTE;
      AJUSTE: estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    carga    = acepta;
    desplaza = (estado == ITERA);
    restaura = desplaza && t_neg;
    ocupado  = (estado != REPOSO);
  end

  caminodatos_div #(.N(N)) u_dp (
    .clk      (clk),
    .reset    (reset),
    .carga    (carga),
    .desplaza (desplaza),
    .restaura (restaura),
    .dvd_mag  (dvd_mag),
    .dvs_mag  (dvs_mag),
    .a        (a),
    .q        (q),
    .t_neg    (t_neg)
  );

  // Result registers hold until the next AJUSTE; sign correction gives truncating division.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      sgn_dvd  <= 1'b0;
      sgn_dvs  <= 1'b0;
      es_cero  <= 1'b0;
      cociente <= '0;
      resto    <= '0;
      listo    <= 1'b0;
      div_cero <= 1'b0;
    end else begin
      listo <= 1'b0;
      if (acepta) begin
        cnt      <= CW'(N);
        sgn_dvd  <= sgn_dvd_in;
        sgn_dvs  <= sgn_dvs_in;
        es_cero  <= (divisor == '0);
        div_cero <= 1'b0;
      end
      if (estado == ITERA) cnt <= cnt - CW'(1);
      if (estado == AJUSTE) begin
        listo <= 1'b1;
        if (es_cero) begin
          cociente <= {N{COC_DIV0_BIT}};
          resto    <= sgn_dvd ? negar(q) : q;
          div_cero <= 1'b1;
        end else begin
          cociente <= (sgn_dvd ^ sgn_dvs) ? negar(q) : q;
          resto    <= sgn_dvd ? negar(a[N-1:0]) : a[N-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: vector table, handshake, reset abort and exhaustive sweep.
// Signed N=3 when DIVISOR_CON_SIGNO_EN is defined, unsigned N=4 otherwise.
module tb_divisor_secuencial;

`ifdef DIVISOR_CON_SIGNO_EN
  localparam int N = 3;
`else
  localparam int N = 4;
`endif

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividendo = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] cociente, resto;
  logic         listo, ocupado, div_cero;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[8];

  divisor_secuencial #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .resto     (resto),
    .listo     (listo),
    .ocupado   (ocupado),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] a, b, q, r, input logic dz);
    vec_t v;
    v.a = a; v.b = b; v.e.q = q; v.e.r = r; v.e.dz = dz;
    return v;
  endfunction

  function automatic exp_t ref_div(input logic [N-1:0] a, b);
    exp_t e;
    int   x, y;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
`ifdef DIVISOR_CON_SIGNO_EN
      x = int'($signed(a));
      y = int'($signed(b));
`else
      x = int'(a);
      y = int'(b);
`endif
      e.q = N'(x / y); e.r = N'(x % y); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard: every listo pulse must consume exactly one pending expectation.
  always @(negedge clk) begin
    if (listo) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL listo_spurious: got listo=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        chk("cociente", 32'(cociente), 32'(mon_e.q));
        chk("resto", 32'(resto), 32'(mon_e.r));
        chk("div_cero", 32'(div_cero), 32'(mon_e.dz));
      end
    end
  end

  // One accepted division: checks listo latency and ocupado duration; scrambles operands after acceptance.
  task automatic run_op(input logic [N-1:0] a, b, input exp_t e);
    int lat, busy;
    @(negedge clk);
    dividendo = a; divisor = b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; dividendo = ~a; divisor = ~b;
    lat = 0; busy = 0;
    for (int k = 1; k <= N + 6 && lat == 0; k++) begin
      @(negedge clk);
      if (listo) lat = k;
      else if (ocupado) busy++;
    end
    chk("latency", 32'(lat), (b == '0) ? 32'd2 : 32'(N + 2));
    chk("ocupado_cycles", 32'(busy), (b == '0) ? 32'd1 : 32'(N + 1));
  endtask

  initial begin
    int lat, busy, pulses;
    exp_t e1, e2;

`ifdef DIVISOR_CON_SIGNO_EN
    tbl[0] = mk(3'b011, 3'b010, 3'b001, 3'b001, 1'b0);
    tbl[1] = mk(3'b101, 3'b010, 3'b111, 3'b111, 1'b0);
    tbl[2] = mk(3'b011, 3'b110, 3'b111, 3'b001, 1'b0);
    tbl[3] = mk(3'b100, 3'b111, 3'b100, 3'b000, 1'b0);
    tbl[4] = mk(3'b010, 3'b000, 3'b111, 3'b010, 1'b1);
    tbl[5] = mk(3'b001, 3'b001, 3'b001, 3'b000, 1'b0);
    tbl[6] = mk(3'b111, 3'b011, 3'b000, 3'b111, 1'b0);
    tbl[7] = mk(3'b110, 3'b110, 3'b001, 3'b000, 1'b0);
`else
    tbl[0] = mk(4'd13, 4'd4,  4'd3,  4'd1, 1'b0);
    tbl[1] = mk(4'd2,  4'd0,  4'd15, 4'd2, 1'b1);
    tbl[2] = mk(4'd1,  4'd1,  4'd1,  4'd0, 1'b0);
    tbl[3] = mk(4'd15, 4'd1,  4'd15, 4'd0, 1'b0);
    tbl[4] = mk(4'd0,  4'd5,  4'd0,  4'd0, 1'b0);
    tbl[5] = mk(4'd9,  4'd15, 4'd0,  4'd9, 1'b0);
    tbl[6] = mk(4'd15, 4'd2,  4'd7,  4'd1, 1'b0);
    tbl[7] = mk(4'd8,  4'd3,  4'd2,  4'd2, 1'b0);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cociente", 32'(cociente), 32'd0);
    chk("rst_resto", 32'(resto), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_div_cero", 32'(div_cero), 32'd0);

    for (int i = 0; i < 8; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].e);

    // start held high: accepted at E0, ignored while busy, re-accepted the edge after listo's cycle
    e1 = tbl[0].e;
    e2 = tbl[7].e;
    @(negedge clk);
    dividendo = tbl[0].a; divisor = tbl[0].b; start = 1'b1;
    sb.push_back(e1);
    @(posedge clk);
    #1 dividendo = tbl[7].a; divisor = tbl[7].b;
    sb.push_back(e2);
    lat = 0; busy = 0;
    for (int k = 1; k <= N + 6 && lat == 0; k++) begin
      @(negedge clk);
      if (listo) lat = k;
      else if (ocupado) busy++;
    end
    chk("hold_latency1", 32'(lat), 32'(N + 2));
    chk("hold_busy1", 32'(busy), 32'(N + 1));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("hold_rearm_ocupado", 32'(ocupado), 32'd1);
    lat = 0;
    for (int k = 2; k <= N + 6 && lat == 0; k++) begin
      @(negedge clk);
      if (listo) lat = k;
    end
    chk("hold_latency2", 32'(lat), 32'(N + 2));

    // Reset asserted at E2 aborts the division; a prior div0 result makes the clear visible
    run_op(N'(2), '0, ref_div(N'(2), '0));
    @(negedge clk);
    dividendo = N'(3); divisor = N'(1); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_cociente", 32'(cociente), 32'd0);
    chk("abort_resto", 32'(resto), 32'd0);
    chk("abort_div_cero", 32'(div_cero), 32'd0);
    pulses = 0;
    for (int k = 0; k < N + 4; k++) begin
      if (listo) pulses++;
      @(negedge clk);
    end
    chk("abort_no_listo", 32'(pulses), 32'd0);

    // Exhaustive sweep against the arithmetic reference
    for (int x = 0; x < (1 << N); x++)
      for (int y = 0; y < (1 << N); y++)
        run_op(N'(x), N'(y), ref_div(N'(x), N'(y)));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
